flag_branch_resolver: RTL and testbench
=======================================

Name: flag_branch_resolver

Overview:
- Consumer end of the arithmetic unit's V/N/Z flag interface.
- Holds the architectural flag register, updated per flag from ALU results.
- Evaluates 3-bit branch condition codes against the flags and issues a registered redirect (taken flag plus next PC) to fetch through a valid/ack handshake.
- Sits between EX (flag producer) and the fetch PC mux.

Parameters:
- AW, 16, PC/target width in bits.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- flag_we  input  3  per-flag write enable: [2]=Z, [1]=V, [0]=N
- z_in  input  1  zero flag from arithmetic unit
- v_in  input  1  saturation/overflow flag from arithmetic unit
- n_in  input  1  negative flag from arithmetic unit
- br_valid  input  1  branch request present this cycle
- br_ready  output  1  resolver can accept a branch request
- br_cond  input  3  condition code
- br_target  input  AW  branch target address
- pc_plus  input  AW  fall-through address
- stall  input  1  pipeline stall; freezes flags and accept
- flush  input  1  squash; drops any pending or incoming branch
- flags_q  output  3  registered {Z,V,N}
- rd_valid  output  1  redirect valid
- rd_ack  input  1  fetch consumed redirect
- rd_taken  output  1  branch condition true
- rd_pc  output  AW  rd_taken ? target : pc_plus

Behaviour:
- Reset (async, rst_n=0): flags_q=3'b000, rd_valid=0, rd_taken=0, rd_pc=0, FSM=IDLE, br_ready=1.
- Flag register:
  - On a clock edge with stall=0, each flags_q bit whose flag_we bit is 1 loads its input; bits with flag_we=0 hold.
  - stall=1 blocks all flag writes.
  - flush does not block flag writes; they come from an older instruction.
- Condition evaluation uses the value of flags_q before this cycle's write (no bypass; see Optional Feature):
  - 000 NE: Z==0
  - 001 EQ: Z==1
  - 010 GT: Z==0 && N==0
  - 011 LT: N==1
  - 100 GE: Z==1 || N==0
  - 101 LE: Z==1 || N==1
  - 110 OV: V==1
  - 111 UN: always taken
- FSM has 2 states:
  - IDLE: br_ready=1.
    - An accept is br_valid && !stall && !flush.
    - On accept, next edge: rd_valid=1, rd_taken=cond result, rd_pc per the mux, go to HOLD.
    - Latency is 1 cycle from accept to rd_valid.
  - HOLD: br_ready=0. rd_valid, rd_taken and rd_pc stay stable until rd_ack=1.
    - On an edge with rd_ack=1: rd_valid=0, go to IDLE.
    - No new branch is accepted in the same cycle as the ack; the next accept is possible one cycle later.
- Priority, highest first: rst_n > flush > stall > ack/accept.
  - flush=1 in any state: next edge rd_valid=0, FSM=IDLE, incoming br_valid ignored. rd_taken and rd_pc hold their old values.
  - stall=1 in HOLD does not block rd_ack (fetch-side handshake).
  - stall=1 in IDLE blocks accept.
- Reset asserted mid-HOLD: outputs return to reset values immediately (asynchronous), with no partial redirect.
- br_valid while br_ready=0 is ignored; the sender must hold the request.
- rd_pc is an AW-bit mux with no arithmetic and no wrap handling. The caller supplies pc_plus already incremented.

Optional Feature:
- Macro FLAG_FWD_EN.
- When defined: condition evaluation uses the forwarded flags. For each bit, if flag_we is set and stall=0, that cycle's z_in/v_in/n_in is used; otherwise flags_q. A flag-setting ALU op and its dependent branch may then resolve in the same cycle.
- When not defined: evaluation uses flags_q only. The dependent branch must arrive at least one cycle after the flag write.
- flags_q update timing is identical in both builds.

Test Plan:
- Reset then flag write: rst_n low, then high; flag_we=3'b111 with z=1, v=0, n=0 -> flags_q=3'b100 next cycle. Then br_cond=001 (EQ), target=16'h0040, pc_plus=16'h0011 -> 1 cycle later rd_valid=1, rd_taken=1, rd_pc=16'h0040.
- Partial write and NE: flags_q=100; flag_we=3'b001 with n=1 -> flags_q=101. br_cond=000 -> rd_taken=0, rd_pc=pc_plus=16'h0011.
- Handshake hold: withhold rd_ack for 4 cycles -> rd_valid/rd_pc stable and br_ready=0 throughout. A br_valid pulse during that window is ignored. Assert rd_ack -> rd_valid=0 next cycle, br_ready=1.
- Flush: assert flush in HOLD -> rd_valid=0 next edge. Assert flush together with br_valid in IDLE -> no redirect. A flag write in the same cycle still updates flags_q.
- Same-cycle dependency: flags_q=000; flag_we=3'b010 with v=1 and br_cond=110 in the same cycle -> rd_taken=1 with FLAG_FWD_EN defined, rd_taken=0 without it.
- Stall and async reset: stall=1 with flag_we=3'b111 and br_valid=1 -> flags_q unchanged, no accept. Drop rst_n mid-HOLD between clock edges -> rd_valid=0 and flags_q=000 immediately.

Source files
------------

// File: rtl/flag_branch_resolver.sv
// Flag register plus branch-condition resolver that issues a registered redirect to fetch.
// Define FLAG_FWD_EN to evaluate conditions on same-cycle forwarded flags instead of flags_q.
module flag_branch_resolver #(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [2:0]    flag_we,
  input  logic          z_in,
  input  logic          v_in,
  input  logic          n_in,
  input  logic          br_valid,
  output logic          br_ready,
  input  logic [2:0]    br_cond,
  input  logic [AW-1:0] br_target,
  input  logic [AW-1:0] pc_plus,
  input  logic          stall,
  input  logic          flush,
  output logic [2:0]    flags_q,
  output logic          rd_valid,
  input  logic          rd_ack,
  output logic          rd_taken,
  output logic [AW-1:0] rd_pc,
  output logic          state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid and ready
  // (br_ready / rd_ack) are both high; valid holds its payload stable until then.
  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t        state_q, state_d;
  logic          rd_taken_q, rd_taken_d;
  logic [AW-1:0] rd_pc_q, rd_pc_d;
  logic [2:0]    flags_d;
  logic [2:0]    flag_in;
  logic [2:0]    eval_flags;
  logic          cond_true;

  assign flag_in = {z_in, v_in, n_in};

  always_comb begin
    flags_d = flags_q;
    for (int i = 0; i < 3; i++) begin
      if (!stall && flag_we[i]) flags_d[i] = flag_in[i];
    end
  end

`ifdef FLAG_FWD_EN
  assign eval_flags = flags_d;
`else
  assign eval_flags = flags_q;
`endif

  // eval_flags is {Z, V, N}
  always_comb begin
    cond_true = 1'b0;
    unique case (br_cond)
      3'b000: cond_true = !eval_flags[2];
      3'b001: cond_true = eval_flags[2];
      3'b010: cond_true = !eval_flags[2] && !eval_flags[0];
      3'b011: cond_true = eval_flags[0];
      3'b100: cond_true = eval_flags[2] || !eval_flags[0];
      3'b101: cond_true = eval_flags[2] || eval_flags[0];
      3'b110: cond_true = eval_flags[1];
      default: cond_true = 1'b1;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    rd_taken_d = rd_taken_q;
    rd_pc_d    = rd_pc_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (br_valid && !stall) begin
            state_d    = HOLD;
            rd_taken_d = cond_true;
            rd_pc_d    = cond_true ? br_target : pc_plus;
          end
        end
        HOLD: begin
          // The fetch-side ack is honoured even while the pipeline is stalled.
          if (rd_ack) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rd_taken_q <= 1'b0;
      rd_pc_q    <= '0;
      flags_q    <= 3'b000;
    end else begin
      state_q    <= state_d;
      rd_taken_q <= rd_taken_d;
      rd_pc_q    <= rd_pc_d;
      flags_q    <= flags_d;
    end
  end

  assign br_ready  = (state_q == IDLE);
  assign rd_valid  = (state_q == HOLD);
  assign rd_taken  = rd_taken_q;
  assign rd_pc     = rd_pc_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_flag_branch_resolver.sv
// Directed-vector bench for flag_branch_resolver; expectations are hand-computed from the flag/condition table.
module tb_flag_branch_resolver;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [2:0]    flag_we;
  logic          z_in, v_in, n_in;
  logic          br_valid;
  logic          br_ready;
  logic [2:0]    br_cond;
  logic [AW-1:0] br_target, pc_plus;
  logic          stall, flush;
  logic [2:0]    flags_q;
  logic          rd_valid, rd_ack, rd_taken;
  logic [AW-1:0] rd_pc;
  logic          state_dbg;

  int n_cmp = 0;
  int n_err = 0;

  flag_branch_resolver #(.AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .flag_we(flag_we), .z_in(z_in), .v_in(v_in), .n_in(n_in),
    .br_valid(br_valid), .br_ready(br_ready), .br_cond(br_cond), .br_target(br_target),
    .pc_plus(pc_plus), .stall(stall), .flush(flush), .flags_q(flags_q), .rd_valid(rd_valid),
    .rd_ack(rd_ack), .rd_taken(rd_taken), .rd_pc(rd_pc), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_flags(input logic [2:0] we, input logic z, input logic v, input logic n);
    flag_we = we; z_in = z; v_in = v; n_in = n;
    step();
    flag_we = 3'b000;
  endtask

  task automatic do_branch(input string tag, input logic [2:0] cond, input logic [AW-1:0] tgt,
                           input logic [AW-1:0] fall, input logic exp_taken);
    br_valid = 1'b1; br_cond = cond; br_target = tgt; pc_plus = fall;
    step();
    br_valid = 1'b0;
    chk({tag, "_valid"}, rd_valid, 1'b1);
    chk({tag, "_taken"}, rd_taken, exp_taken);
    chk({tag, "_pc"}, rd_pc, exp_taken ? tgt : fall);
    rd_ack = 1'b1;
    step();
    rd_ack = 1'b0;
    chk({tag, "_acked"}, rd_valid, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; flag_we = 3'b000; z_in = 0; v_in = 0; n_in = 0;
    br_valid = 0; br_cond = 3'b000; br_target = '0; pc_plus = '0;
    stall = 0; flush = 0; rd_ack = 0;
    #3;
    chk("rst_flags", flags_q, 3'b000);
    chk("rst_valid", rd_valid, 1'b0);
    chk("rst_taken", rd_taken, 1'b0);
    chk("rst_pc", rd_pc, 16'h0000);
    chk("rst_ready", br_ready, 1'b1);
    chk("rst_state", state_dbg, 1'b0);
    rst_n = 1'b1;
    step();

    // Full flag write then EQ taken
    set_flags(3'b111, 1'b1, 1'b0, 1'b0);
    chk("wr_all", flags_q, 3'b100);
    do_branch("eq", 3'b001, 16'h0040, 16'h0011, 1'b1);

    // Partial write of N only, then NE not taken
    set_flags(3'b001, 1'b0, 1'b0, 1'b1);
    chk("wr_n", flags_q, 3'b101);
    br_valid = 1'b1; br_cond = 3'b000; br_target = 16'h0040; pc_plus = 16'h0011;
    step();
    br_valid = 1'b0;
    chk("ne_valid", rd_valid, 1'b1);
    chk("ne_taken", rd_taken, 1'b0);
    chk("ne_pc", rd_pc, 16'h0011);

    // Withhold ack for 4 cycles; a request in that window is ignored
    for (int i = 0; i < 4; i++) begin
      br_valid = (i == 1); br_cond = 3'b111; br_target = 16'h0099; pc_plus = 16'h0077;
      step();
      chk("hold_valid", rd_valid, 1'b1);
      chk("hold_pc", rd_pc, 16'h0011);
      chk("hold_taken", rd_taken, 1'b0);
      chk("hold_ready", br_ready, 1'b0);
    end
    // Ack with a request present: not accepted in the ack cycle
    rd_ack = 1'b1; br_valid = 1'b1; br_cond = 3'b111; br_target = 16'h0099;
    step();
    rd_ack = 1'b0;
    chk("ack_valid", rd_valid, 1'b0);
    chk("ack_ready", br_ready, 1'b1);
    step();
    br_valid = 1'b0;
    chk("next_valid", rd_valid, 1'b1);
    chk("next_taken", rd_taken, 1'b1);
    chk("next_pc", rd_pc, 16'h0099);

    // Flush in HOLD drops redirect; taken/pc keep old values
    flush = 1'b1;
    step();
    chk("flush_hold_valid", rd_valid, 1'b0);
    chk("flush_hold_taken", rd_taken, 1'b1);
    chk("flush_hold_pc", rd_pc, 16'h0099);
    // Flush with incoming request in IDLE, while a flag write still lands
    br_valid = 1'b1; br_cond = 3'b111; br_target = 16'h0055;
    flag_we = 3'b100; z_in = 1'b0;
    step();
    flush = 1'b0; br_valid = 1'b0; flag_we = 3'b000;
    chk("flush_idle_valid", rd_valid, 1'b0);
    chk("flush_idle_ready", br_ready, 1'b1);
    chk("flush_flag_wr", flags_q, 3'b001);
    step();
    chk("flush_idle_later", rd_valid, 1'b0);

    // Stall blocks both flag write and accept
    stall = 1'b1; flag_we = 3'b111; z_in = 1; v_in = 1; n_in = 0;
    br_valid = 1'b1; br_cond = 3'b111;
    step();
    chk("stall_flags", flags_q, 3'b001);
    chk("stall_valid", rd_valid, 1'b0);
    stall = 1'b0; flag_we = 3'b000; br_valid = 1'b0;

    // Same-cycle flag write and dependent OV branch
    set_flags(3'b111, 1'b0, 1'b0, 1'b0);
    chk("zero_flags", flags_q, 3'b000);
    flag_we = 3'b010; v_in = 1'b1;
    br_valid = 1'b1; br_cond = 3'b110; br_target = 16'h0123; pc_plus = 16'h0456;
    step();
    flag_we = 3'b000; br_valid = 1'b0;
    chk("dep_flags", flags_q, 3'b010);
    chk("dep_valid", rd_valid, 1'b1);
`ifdef FLAG_FWD_EN
    chk("dep_taken", rd_taken, 1'b1);
    chk("dep_pc", rd_pc, 16'h0123);
`else
    chk("dep_taken", rd_taken, 1'b0);
    chk("dep_pc", rd_pc, 16'h0456);
`endif
    rd_ack = 1'b1;
    step();
    rd_ack = 1'b0;

    // Condition table sweep; flags are {Z,V,N}
    do_branch("gt_010", 3'b010, 16'h1000, 16'h2000, 1'b1);
    do_branch("lt_010", 3'b011, 16'h1001, 16'h2001, 1'b0);
    do_branch("ge_010", 3'b100, 16'h1002, 16'h2002, 1'b1);
    do_branch("le_010", 3'b101, 16'h1003, 16'h2003, 1'b0);
    do_branch("ov_010", 3'b110, 16'h1004, 16'h2004, 1'b1);
    do_branch("ne_010", 3'b000, 16'h1005, 16'h2005, 1'b1);
    do_branch("eq_010", 3'b001, 16'h1006, 16'h2006, 1'b0);
    set_flags(3'b111, 1'b0, 1'b0, 1'b1);
    do_branch("gt_001", 3'b010, 16'h1010, 16'h2010, 1'b0);
    do_branch("lt_001", 3'b011, 16'h1011, 16'h2011, 1'b1);
    do_branch("ge_001", 3'b100, 16'h1012, 16'h2012, 1'b0);
    do_branch("le_001", 3'b101, 16'h1013, 16'h2013, 1'b1);
    do_branch("ov_001", 3'b110, 16'h1014, 16'h2014, 1'b0);
    set_flags(3'b111, 1'b1, 1'b0, 1'b0);
    do_branch("le_100", 3'b101, 16'h1020, 16'h2020, 1'b1);
    do_branch("ge_100", 3'b100, 16'h1021, 16'h2021, 1'b1);
    do_branch("gt_100", 3'b010, 16'h1022, 16'h2022, 1'b0);
    do_branch("un_100", 3'b111, 16'hFFFF, 16'h0000, 1'b1);

    // Async reset mid-HOLD, between clock edges
    br_valid = 1'b1; br_cond = 3'b111; br_target = 16'hABCD;
    step();
    br_valid = 1'b0;
    chk("pre_rst_valid", rd_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", rd_valid, 1'b0);
    chk("arst_flags", flags_q, 3'b000);
    chk("arst_taken", rd_taken, 1'b0);
    chk("arst_pc", rd_pc, 16'h0000);
    chk("arst_ready", br_ready, 1'b1);
    rst_n = 1'b1;
    step();
    chk("post_rst_valid", rd_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
